// File: rtl/dec_pkg.sv
// ----------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the polarity-controlled N-to-2^N decoder family.
//   mode_e        : operating-mode encodings presented on the 2-bit mode port
//   N_MIN / N_MAX : legal range of the select width N
// ----------------------------------------------------------------------------
package dec_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_DIRECT  = 2'b01,
        MODE_SCAN_UP = 2'b10,
        MODE_SCAN_DN = 2'b11
    } mode_e;

    localparam int N_MIN = 1;
    localparam int N_MAX = 6;

endpackage : dec_pkg

// File: rtl/dec_onehot.sv
// ----------------------------------------------------------------------------
// dec_onehot
// Purely combinational one-hot expansion of an N-bit index: o_onehot = 1 << i_idx.
//   i_idx    in  N     : index to expand
//   o_onehot out 2**N  : exactly one bit set, at position i_idx
// ----------------------------------------------------------------------------
module dec_onehot #(
    parameter int N = 2
) (
    input  logic [N-1:0]      i_idx,
    output logic [(2**N)-1:0] o_onehot
);

    localparam int M = 2 ** N;

    assign o_onehot = M'(1) << i_idx;

endmodule : dec_onehot

// File: rtl/dec_n_pol_scan.sv
// ----------------------------------------------------------------------------
// dec_n_pol_scan
// Registered N-to-2^N decoder with runtime output polarity. Either decodes a
// loaded select value (DIRECT) or scans a one-hot pattern up or down with a
// programmable dwell per output (SCAN_UP / SCAN_DN). All outputs derive only
// from registers; no input reaches o_y combinationally.
//
// Ports
//   i_clk        in  1        rising-edge clock
//   i_rst_n      in  1        synchronous active-low reset (wins over i_en)
//   i_en         in  1        clock enable; low freezes every register
//   i_mode       in  2        00 OFF, 01 DIRECT, 10 SCAN_UP, 11 SCAN_DN
//   i_sel        in  N        select value, loaded on i_sel_valid
//   i_sel_valid  in  1        single-cycle load strobe for i_sel
//   i_pol        in  1        0 = active-high one-hot, 1 = active-low
//   i_dwell      in  DWELL_W  each scan index is held for i_dwell+1 cycles
//   o_y          out 2**N     decoded outputs
//   o_idx        out N        current index register
//   o_wrap       out 1        one-cycle pulse when a scan wraps
// ----------------------------------------------------------------------------
module dec_n_pol_scan
    import dec_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [1:0]           i_mode,
    input  logic [N-1:0]         i_sel,
    input  logic                 i_sel_valid,
    input  logic                 i_pol,
    input  logic [DWELL_W-1:0]   i_dwell,
    output logic [(2**N)-1:0]    o_y,
    output logic [N-1:0]         o_idx,
    output logic                 o_wrap
);

    localparam int M = 2 ** N;

    localparam logic [N-1:0]       IDX_ONE  = N'(1);
    localparam logic [N-1:0]       IDX_LAST = N'(M - 1);
    localparam logic [DWELL_W-1:0] DCNT_ONE = DWELL_W'(1);

    // Reject out-of-range select widths at elaboration time.
    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("dec_n_pol_scan: N must lie in %0d..%0d", N_MIN, N_MAX);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [N-1:0]       r_cur_idx;
    logic               r_active;
    logic               r_pol_q;
    logic [DWELL_W-1:0] r_dcnt;
    logic               r_wrap_q;

    // ------------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------------
    mode_e              w_mode;
    logic               w_dwell_done;
    logic [N-1:0]       w_idx_nxt;
    logic               w_active_nxt;
    logic [DWELL_W-1:0] w_dcnt_nxt;
    logic               w_wrap_nxt;
    logic [M-1:0]       w_onehot;

    assign w_mode = mode_e'(i_mode);

    // ">=" rather than "==" so that lowering the dwell below the running
    // count forces a step on the next cycle instead of counting round.
    assign w_dwell_done = (r_dcnt >= i_dwell);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_idx_nxt    = r_cur_idx;
        w_active_nxt = r_active;
        w_dcnt_nxt   = r_dcnt;
        w_wrap_nxt   = 1'b0;

        case (w_mode)
            MODE_OFF: begin
                w_active_nxt = 1'b0;
                w_dcnt_nxt   = '0;
                if (i_sel_valid) begin
                    w_idx_nxt = i_sel;
                end
            end

            MODE_DIRECT: begin
                w_dcnt_nxt = '0;
                if (i_sel_valid) begin
                    w_idx_nxt    = i_sel;
                    w_active_nxt = 1'b1;
                end
            end

            MODE_SCAN_UP, MODE_SCAN_DN: begin
                w_active_nxt = 1'b1;
                // A load overrides any same-cycle step and suppresses wrap.
                // Entering a scan needs no special case: OFF and DIRECT keep
                // the dwell counter cleared, and UP<->DN keeps it as-is.
                if (i_sel_valid) begin
                    w_idx_nxt  = i_sel;
                    w_dcnt_nxt = '0;
                end else if (w_dwell_done) begin
                    w_dcnt_nxt = '0;
                    if (w_mode == MODE_SCAN_UP) begin
                        w_idx_nxt  = r_cur_idx + IDX_ONE;
                        w_wrap_nxt = (r_cur_idx == IDX_LAST);
                    end else begin
                        w_idx_nxt  = r_cur_idx - IDX_ONE;
                        w_wrap_nxt = (r_cur_idx == '0);
                    end
                end else begin
                    // Cannot overflow: only reached while r_dcnt < i_dwell.
                    w_dcnt_nxt = r_dcnt + DCNT_ONE;
                end
            end

            default: begin
                w_active_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cur_idx <= '0;
            r_active  <= 1'b0;
            r_pol_q   <= 1'b0;
            r_dcnt    <= '0;
            r_wrap_q  <= 1'b0;
        end else if (i_en) begin
            r_cur_idx <= w_idx_nxt;
            r_active  <= w_active_nxt;
            r_pol_q   <= i_pol;
            r_dcnt    <= w_dcnt_nxt;
            r_wrap_q  <= w_wrap_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: one-hot expansion, gated by active, then polarity XOR.
    // ------------------------------------------------------------------------
    dec_onehot #(
        .N(N)
    ) u_onehot (
        .i_idx    (r_cur_idx),
        .o_onehot (w_onehot)
    );

    assign o_y    = {M{r_pol_q}} ^ (r_active ? w_onehot : '0);
    assign o_idx  = r_cur_idx;
    assign o_wrap = r_wrap_q;

endmodule : dec_n_pol_scan

// File: tb/tb_dec_n_pol_scan.sv
// ----------------------------------------------------------------------------
// tb_dec_n_pol_scan
// Drives an N=2 and an N=3 instance with identical stimulus. A behavioural
// model (plain integer arithmetic) predicts each cycle's outputs, pushes them
// into per-instance queues, and a monitor pops and compares after each edge.
// ----------------------------------------------------------------------------
module tb_dec_n_pol_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] sel3 = 3'd0;
    logic [1:0] sel2 = 2'd0;
    logic       sel_valid = 1'b0;
    logic       pol = 1'b0;
    logic [3:0] dwell = 4'd0;

    logic [3:0] y2;
    logic [1:0] idx2;
    logic       wrap2;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       wrap3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dec_n_pol_scan #(.N(2), .DWELL_W(4)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sel(sel2),
        .i_sel_valid(sel_valid), .i_pol(pol), .i_dwell(dwell),
        .o_y(y2), .o_idx(idx2), .o_wrap(wrap2)
    );

    dec_n_pol_scan #(.N(3), .DWELL_W(4)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sel(sel3),
        .i_sel_valid(sel_valid), .i_pol(pol), .i_dwell(dwell),
        .o_y(y3), .o_idx(idx3), .o_wrap(wrap3)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        int idx;
        int act;
        int pol;
        int dcnt;
        int wrap;
    } mstate_t;

    typedef struct {
        int y;
        int idx;
        int wrap;
    } exp_t;

    mstate_t s2, s3;
    exp_t    q2[$];
    exp_t    q3[$];

    function automatic mstate_t mstep(mstate_t s, int n, bit r_n, bit e,
                                      int md, int sl, bit sv, bit p, int dw);
        int      m;
        mstate_t r;
        m = 1 << n;
        r = s;
        if (!r_n) begin
            r = '{default: 0};
            return r;
        end
        if (!e) return s;
        r.pol  = p;
        r.wrap = 0;
        if (md == 0) begin
            r.act  = 0;
            r.dcnt = 0;
            if (sv) r.idx = sl % m;
        end else if (md == 1) begin
            r.dcnt = 0;
            if (sv) begin
                r.idx = sl % m;
                r.act = 1;
            end
        end else begin
            r.act = 1;
            if (sv) begin
                r.idx  = sl % m;
                r.dcnt = 0;
            end else if (s.dcnt >= dw) begin
                r.dcnt = 0;
                if (md == 2) begin
                    r.idx  = (s.idx + 1) % m;
                    r.wrap = (r.idx == 0) ? 1 : 0;
                end else begin
                    r.idx  = (s.idx + m - 1) % m;
                    r.wrap = (r.idx == m - 1) ? 1 : 0;
                end
            end else begin
                r.dcnt = s.dcnt + 1;
            end
        end
        return r;
    endfunction

    function automatic exp_t mkexp(mstate_t s, int n);
        exp_t e;
        int   m;
        m     = 1 << n;
        e.y   = (s.act != 0) ? (1 << s.idx) : 0;
        if (s.pol != 0) e.y = e.y ^ ((1 << m) - 1);
        e.idx  = s.idx;
        e.wrap = s.wrap;
        return e;
    endfunction

    task automatic check(string name, int actual, int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict, enqueue.
    task automatic cyc(bit r_n, bit e, int md, int sl, bit sv, bit p, int dw);
        @(negedge clk);
        rst_n     = r_n;
        en        = e;
        mode      = md[1:0];
        sel3      = sl[2:0];
        sel2      = sl[1:0];
        sel_valid = sv;
        pol       = p;
        dwell     = dw[3:0];
        s2 = mstep(s2, 2, r_n, e, md, sl, sv, p, dw);
        s3 = mstep(s3, 3, r_n, e, md, sl, sv, p, dw);
        q2.push_back(mkexp(s2, 2));
        q3.push_back(mkexp(s3, 3));
    endtask

    // Wait until just after the edge that consumed the last cyc() stimulus.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: outputs are valid every cycle, so one pop per edge.
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("y_n2",    int'(y2),    e.y);
            check("idx_n2",  int'(idx2),  e.idx);
            check("wrap_n2", int'(wrap2), e.wrap);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("y_n3",    int'(y3),    e.y);
            check("idx_n3",  int'(idx3),  e.idx);
            check("wrap_n3", int'(wrap3), e.wrap);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        s2 = '{default: 0};
        s3 = '{default: 0};

        // Reset state.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        settle();
        check("reset_y",    int'(y2),    0);
        check("reset_idx",  int'(idx2),  0);
        check("reset_wrap", int'(wrap2), 0);

        // OFF with inverted polarity: all outputs high.
        cyc(1, 1, 0, 0, 0, 1, 0);
        settle();
        check("off_pol_y_n2", int'(y2), 'hF);
        check("off_pol_y_n3", int'(y3), 'hFF);

        // DIRECT decode and polarity changes.
        cyc(1, 1, 1, 2, 1, 0, 0);
        settle();
        check("direct_sel2", int'(y2), 'b0100);
        cyc(1, 1, 1, 0, 0, 1, 0);
        settle();
        check("direct_pol1", int'(y2), 'b1011);
        cyc(1, 1, 1, 3, 1, 1, 0);
        settle();
        check("direct_sel3", int'(y2), 'b0111);

        // SCAN_UP, dwell=1, from idx 0: full pass plus wrap.
        cyc(1, 1, 1, 0, 1, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 1, 2, 0, 0, 0, 1);

        // SCAN_DN, dwell=0, from idx 1; load on the would-be wrap cycle.
        cyc(1, 1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 3, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 1, 3, 2, 1, 0, 0);
        settle();
        check("dn_load_on_wrap_idx",  int'(idx2),  2);
        check("dn_load_on_wrap_wrap", int'(wrap2), 0);

        // Enable freeze mid-dwell, then resume.
        for (int i = 0; i < 2; i++) cyc(1, 1, 2, 0, 0, 0, 3);
        for (int i = 0; i < 5; i++) cyc(1, 0, 2, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 2, 0, 0, 0, 3);

        // Switching UP<->DN keeps index and count.
        for (int i = 0; i < 4; i++) cyc(1, 1, 3, 0, 0, 0, 2);
        for (int i = 0; i < 4; i++) cyc(1, 1, 2, 0, 0, 0, 2);

        // Mid-scan reset with inverted polarity; reset wins over en=0.
        for (int i = 0; i < 5; i++) cyc(1, 1, 2, 0, 0, 1, 0);
        cyc(0, 0, 2, 0, 0, 1, 0);
        settle();
        check("rst_mid_y_n3",    int'(y3),    0);
        check("rst_mid_idx_n3",  int'(idx3),  0);
        check("rst_mid_wrap_n3", int'(wrap3), 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 2, 0, 0, 1, 0);

        // Lowering dwell below the running count forces a step.
        for (int i = 0; i < 6; i++) cyc(1, 1, 2, 0, 0, 0, 9);
        for (int i = 0; i < 4; i++) cyc(1, 1, 2, 0, 0, 0, 2);
        for (int i = 0; i < 20; i++) cyc(1, 1, 3, 0, 0, 0, 15);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            bit r_n, e, sv, p;
            int md, sl, dw;
            r_n = ($urandom_range(0, 59) != 0);
            e   = ($urandom_range(0, 9) < 8);
            md  = (i % 40 < 30) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 3));
            sl  = $urandom_range(0, 7);
            sv  = ($urandom_range(0, 9) == 0);
            p   = $urandom_range(0, 1);
            dw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
            cyc(r_n, e, md, sl, sv, p, dw);
        end

        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        check("drain_q2", q2.size(), 0);
        check("drain_q3", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dec_n_pol_scan
